// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
// Shared definitions for the two-client memory arbiter:
//   - default memory address/data widths used by the arbiter and its mux
//   - default timeout settings for the completion wait
//   - the arbiter state type
//   - the round-robin pick helper
package memory_arbiter_pkg;

  localparam int MEMORY_ADDR_WIDTH      = 16;
  localparam int MEMORY_DATA_WIDTH      = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
  localparam int DEFAULT_CNT_W          = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Returns 1 when B should own the next transaction. With both clients
  // requesting, the one that did not win last time goes next.
  function automatic logic pick_b(input logic req_a,
                                  input logic req_b,
                                  input logic last_grant_b);
    if (req_a && req_b)
      return !last_grant_b;
    return req_b;
  endfunction

endpackage

// File: rtl/memory_arbiter_mux.sv
// memory_arbiter_mux
// Command multiplexer in front of the single-port memory unit. Only the
// selected client's command reaches the arbiter's command registers.
// Ports:
//   sel                 in  : 0 = client A, 1 = client B
//   mem_func_a/b        in  : client memory functions
//   address_a/b         in  : client addresses
//   write_data_a/b      in  : client write data
//   mem_func            out : selected memory function
//   address             out : selected address
//   write_data          out : selected write data
module memory_arbiter_mux #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              sel,
  input  logic [1:0]        mem_func_a,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [DATA_W-1:0] write_data_a,
  input  logic [1:0]        mem_func_b,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] write_data_b,
  output logic [1:0]        mem_func,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data
);

  assign mem_func   = sel ? mem_func_b   : mem_func_a;
  assign address    = sel ? address_b    : address_a;
  assign write_data = sel ? write_data_b : write_data_a;

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Two-client round-robin arbiter and sequencer for the single-port memory
// unit. A granted request is latched into the command registers, started
// with a one-cycle mem_execute pulse, and completed with a one-cycle ack to
// its owner once the memory reports mem_finished (or the wait times out).
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   req_*/mem_func_*/address_*/
//   write_data_*                    : held client requests and commands
//   ack_a, ack_b                    : one-cycle completion pulse per client
//   read_data                       : registered read result, shared
//   mem_func/mem_address/
//   mem_write_data                  : registered command to the memory unit
//   mem_execute                     : one-cycle start pulse
//   mem_finished, mem_read_data     : completion and read data from memory
//   grant_b                         : current owner (1 = B), mux select
//   timeout_err                     : sticky timeout flag, cleared by rst
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W         = MEMORY_ADDR_WIDTH,
  parameter int DATA_W         = MEMORY_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [1:0]        mem_func_a,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [DATA_W-1:0] write_data_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [1:0]        mem_func_b,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] write_data_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] read_data,
  output logic [1:0]        mem_func,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_execute,
  input  logic              mem_finished,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              grant_b,
  output logic              timeout_err
);

  // The counter starts at 0 on the first WAIT cycle, so reaching this value
  // means TIMEOUT_CYCLES wait cycles have elapsed.
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        state;
  logic              last_grant_b;
  logic [CNT_W-1:0]  wait_count;
  logic              next_grant_b;
  logic [1:0]        mux_func;
  logic [ADDR_W-1:0] mux_address;
  logic [DATA_W-1:0] mux_write_data;

  assign next_grant_b = pick_b(req_a, req_b, last_grant_b);

  // The mux is steered by the grant about to be taken, so the command
  // registers capture the new owner's command on the grant edge itself.
  memory_arbiter_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .sel         (next_grant_b),
    .mem_func_a  (mem_func_a),
    .address_a   (address_a),
    .write_data_a(write_data_a),
    .mem_func_b  (mem_func_b),
    .address_b   (address_b),
    .write_data_b(write_data_b),
    .mem_func    (mux_func),
    .address     (mux_address),
    .write_data  (mux_write_data)
  );

  // Pulse outputs default low every cycle and are raised only for the one
  // cycle they belong to; mem_finished is looked at only in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_grant_b   <= 1'b1;
      wait_count     <= '0;
      ack_a          <= 1'b0;
      ack_b          <= 1'b0;
      mem_execute    <= 1'b0;
      mem_func       <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      read_data      <= '0;
      grant_b        <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      mem_execute <= 1'b0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            grant_b        <= next_grant_b;
            last_grant_b   <= next_grant_b;
            mem_func       <= mux_func;
            mem_address    <= mux_address;
            mem_write_data <= mux_write_data;
            mem_execute    <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          wait_count <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (mem_finished) begin
            read_data <= mem_read_data;
            ack_a     <= !grant_b;
            ack_b     <= grant_b;
            state     <= DONE;
          end else if (wait_count == LAST_COUNT) begin
            timeout_err <= 1'b1;
            ack_a       <= !grant_b;
            ack_b       <= grant_b;
            state       <= DONE;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Directed bench for memory_arbiter. A transaction-level model predicts the
// outputs every cycle from the arbitration/latency rules; literal checks in
// the directed tests pin down grant order, latencies and data values.
module tb_memory_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic              clk;
  logic              rst;
  logic              req_a, req_b;
  logic [1:0]        mem_func_a, mem_func_b;
  logic [ADDR_W-1:0] address_a, address_b;
  logic [DATA_W-1:0] write_data_a, write_data_b;
  logic              ack_a, ack_b;
  logic [DATA_W-1:0] read_data;
  logic [1:0]        mem_func;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_execute;
  logic              mem_finished;
  logic [DATA_W-1:0] mem_read_data;
  logic              grant_b;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  memory_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .mem_func_a(mem_func_a), .address_a(address_a),
    .write_data_a(write_data_a), .ack_a(ack_a),
    .req_b(req_b), .mem_func_b(mem_func_b), .address_b(address_b),
    .write_data_b(write_data_b), .ack_b(ack_b),
    .read_data(read_data), .mem_func(mem_func), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_execute(mem_execute),
    .mem_finished(mem_finished), .mem_read_data(mem_read_data),
    .grant_b(grant_b), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Transaction-level model: a grant schedules execute for the next cycle,
  // a WAIT window of TIMEOUT cycles after execute, and an ack one cycle
  // after the window closes (by mem_finished or by the deadline).
  logic              m_busy, m_owner_b, m_last_b;
  int                m_exec_at, m_deadline, m_ack_at;
  logic [1:0]        e_func;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata, e_rdata;
  logic              e_grant_b, e_terr, e_exec, e_ack_a, e_ack_b;

  initial begin
    m_busy = 0; m_owner_b = 0; m_last_b = 1;
    m_exec_at = -1; m_deadline = -1; m_ack_at = -1;
    e_func = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    e_grant_b = 0; e_terr = 0; e_exec = 0; e_ack_a = 0; e_ack_b = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_last_b = 1; m_ack_at = -1; m_exec_at = -1;
        e_func = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
        e_grant_b = 0; e_terr = 0;
      end else if (!m_busy) begin
        if (req_a || req_b) begin
          if (req_a && req_b) m_owner_b = !m_last_b;
          else                m_owner_b = req_b;
          m_last_b   = m_owner_b;
          m_busy     = 1;
          m_exec_at  = cyc + 1;
          m_deadline = cyc + 1 + TIMEOUT;
          m_ack_at   = -1;
          e_grant_b  = m_owner_b;
          e_func     = m_owner_b ? mem_func_b   : mem_func_a;
          e_addr     = m_owner_b ? address_b    : address_a;
          e_wdata    = m_owner_b ? write_data_b : write_data_a;
        end
      end else if (m_ack_at < 0) begin
        if (cyc > m_exec_at) begin
          if (mem_finished) begin
            m_ack_at = cyc + 1;
            e_rdata  = mem_read_data;
          end else if (cyc == m_deadline) begin
            m_ack_at = cyc + 1;
            e_terr   = 1;
          end
        end
      end else if (cyc == m_ack_at) begin
        m_busy = 0;
      end
      cyc++;
      e_exec  = m_busy && (cyc == m_exec_at);
      e_ack_a = m_busy && (cyc == m_ack_at) && !m_owner_b;
      e_ack_b = m_busy && (cyc == m_ack_at) && m_owner_b;
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      checkOutput("mem_execute", mem_execute, e_exec);
      checkOutput("ack_a", ack_a, e_ack_a);
      checkOutput("ack_b", ack_b, e_ack_b);
      checkOutput("ack_exclusive", ack_a & ack_b, 0);
      checkOutput("grant_b", grant_b, e_grant_b);
      checkOutput("mem_func", mem_func, e_func);
      checkOutput("mem_address", mem_address, e_addr);
      checkOutput("mem_write_data", mem_write_data, e_wdata);
      checkOutput("read_data", read_data, e_rdata);
      checkOutput("timeout_err", timeout_err, e_terr);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic to_b, input logic [1:0] func,
                               input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata);
    if (to_b) begin
      mem_func_b = func; address_b = addr; write_data_b = wdata; req_b = 1'b1;
    end else begin
      mem_func_a = func; address_a = addr; write_data_a = wdata; req_a = 1'b1;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitExec(output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_execute === 1'b1) begin
        at = cyc;
        return;
      end
    end
    checks++; errors++;
    $display("[TB] FAIL exec_wait cycle %0d: got no mem_execute expected one within 20 cycles", cyc);
  endtask

  task automatic waitAck(output int at);
    at = -1;
    for (int i = 0; i < 30; i++) begin
      if (ack_a === 1'b1 || ack_b === 1'b1) begin
        at = cyc;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("[TB] FAIL ack_wait cycle %0d: got no ack expected one within 30 cycles", cyc);
  endtask

  // Pulses mem_finished k cycles after the execute cycle, leaving the bench
  // at the cycle where the ack is due.
  task automatic respond(input int k, input logic [DATA_W-1:0] data);
    repeat (k) @(negedge clk);
    mem_finished = 1'b1; mem_read_data = data;
    @(negedge clk);
    mem_finished = 1'b0;
  endtask

  int x, a;
  logic [3:0] grant_order;

  initial begin
    rst = 1'b1;
    req_a = 0; req_b = 0;
    mem_func_a = '0; mem_func_b = '0; address_a = '0; address_b = '0;
    write_data_a = '0; write_data_b = '0;
    mem_finished = 0; mem_read_data = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_grant_b", grant_b, 0);
    checkOutput("reset_timeout_err", timeout_err, 0);
    checkOutput("reset_read_data", read_data, 0);
    rst = 1'b0;

    // 1: single A write, finished 3 cycles after execute.
    applyStimulus(1'b0, 2'd2, 16'h0010, 32'hAB);
    waitExec(x);
    checkOutput("t1_addr", mem_address, 16'h0010);
    checkOutput("t1_func", mem_func, 2'd2);
    checkOutput("t1_wdata", mem_write_data, 32'hAB);
    checkOutput("t1_grant_b", grant_b, 0);
    respond(3, 32'h1234);
    waitAck(a);
    checkOutput("t1_ack_latency", a - x, 4);
    checkOutput("t1_ack_a", ack_a, 1);
    req_a = 0;
    @(negedge clk);
    checkOutput("t1_hold_addr", mem_address, 16'h0010);

    // 2: both held from reset, grants alternate A, B, A, B.
    doReset();
    grant_order = 4'b1010;
    applyStimulus(1'b0, 2'd1, 16'h0A00, 32'hA0);
    applyStimulus(1'b1, 2'd2, 16'h0B00, 32'hB0);
    for (int i = 0; i < 4; i++) begin
      waitExec(x);
      checkOutput("t2_grant_order", grant_b, grant_order[i]);
      respond(1, 32'(i));
      waitAck(a);
      checkOutput("t2_ack_latency", a - x, 2);
      if (i == 3) begin
        req_a = 0; req_b = 0;
      end
    end

    // 3: B read returns data, held afterwards.
    @(negedge clk);
    applyStimulus(1'b1, 2'd0, 16'h0020, 32'h0);
    waitExec(x);
    checkOutput("t3_grant_b", grant_b, 1);
    respond(2, 32'hDEADBEEF);
    waitAck(a);
    checkOutput("t3_ack_b", ack_b, 1);
    checkOutput("t3_read_data", read_data, 32'hDEADBEEF);
    req_b = 0;
    repeat (3) @(negedge clk);
    checkOutput("t3_read_hold", read_data, 32'hDEADBEEF);

    // 4: no completion, timeout after TIMEOUT wait cycles; flag is sticky.
    applyStimulus(1'b0, 2'd0, 16'h0030, 32'h0);
    waitExec(x);
    waitAck(a);
    checkOutput("t4_timeout_latency", a - x, 9);
    checkOutput("t4_timeout_err", timeout_err, 1);
    checkOutput("t4_read_unchanged", read_data, 32'hDEADBEEF);
    req_a = 0;
    @(negedge clk);
    applyStimulus(1'b1, 2'd0, 16'h0040, 32'h0);
    waitExec(x);
    respond(1, 32'h55);
    waitAck(a);
    checkOutput("t4_err_sticky", timeout_err, 1);
    checkOutput("t4_read_after", read_data, 32'h55);
    req_b = 0;

    // 5: reset in WAIT aborts with no ack, then lone B is granted.
    @(negedge clk);
    applyStimulus(1'b0, 2'd1, 16'h0050, 32'h77);
    waitExec(x);
    repeat (2) @(negedge clk);
    rst = 1'b1; req_a = 0;
    @(negedge clk);
    checkOutput("t5_rst_err", timeout_err, 0);
    checkOutput("t5_rst_addr", mem_address, 0);
    checkOutput("t5_rst_ack", ack_a, 0);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 2'd2, 16'h0060, 32'h66);
    waitExec(x);
    checkOutput("t5_grant_b", grant_b, 1);
    respond(1, 32'h0);
    waitAck(a);
    req_b = 0;

    // 6: spurious mem_finished in IDLE and ISSUE are ignored.
    @(negedge clk);
    mem_finished = 1'b1; mem_read_data = 32'h999;
    @(negedge clk);
    mem_finished = 1'b0;
    checkOutput("t6_idle_exec", mem_execute, 0);
    applyStimulus(1'b0, 2'd0, 16'h0070, 32'h0);
    waitExec(x);
    mem_finished = 1'b1; mem_read_data = 32'h777;
    @(negedge clk);
    mem_finished = 1'b0;
    respond(1, 32'h600D);
    waitAck(a);
    checkOutput("t6_ack_latency", a - x, 3);
    checkOutput("t6_read_data", read_data, 32'h600D);
    req_a = 0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
